sc_window_ctrl: RTL and testbench

SC_WINDOW_CTRL -- requirements
Module: sc_window_ctrl

---
 rtl/sc_window_ctrl.sv | 141 ++++++++++++++
 tb/tb_sc_window_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_window_ctrl.sv
// Window controller for a stochastic multiplier: accepts operands, sequences the datapath, counts product ones.
// Optional signed output res_bipolar is enabled by defining SC_BIPOLAR_OUT_EN.
module sc_window_ctrl #(
  parameter int WIN_LOG2 = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [3:0]          op_a,
  input  logic [3:0]          op_b,
  input  logic                abort,
  output logic                dp_load,
  output logic                dp_en,
  output logic [3:0]          dp_a,
  output logic [3:0]          dp_b,
  input  logic                sn_bit,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIN_LOG2:0]   res_count,
`ifdef SC_BIPOLAR_OUT_EN
  output logic signed [WIN_LOG2+1:0] res_bipolar,
`endif
  output logic                busy,
  output logic [2:0]          state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and res_count holds until the result transfer.

  localparam int N       = 1 << WIN_LOG2;
  localparam int CYC_MAX = (PIPE_LAT > N) ? PIPE_LAT : N;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BW      = WIN_LOG2 + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state;
  logic [CYC_W-1:0]   cyc;
  logic [WIN_LOG2:0]  ones;
  logic [WIN_LOG2:0]  final_count;

  assign final_count = ones + {{WIN_LOG2{1'b0}}, sn_bit};
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc       <= '0;
      ones      <= '0;
      op_ready  <= 1'b1;
      busy      <= 1'b0;
      dp_load   <= 1'b0;
      dp_en     <= 1'b0;
      dp_a      <= '0;
      dp_b      <= '0;
      res_valid <= 1'b0;
      res_count <= '0;
`ifdef SC_BIPOLAR_OUT_EN
      res_bipolar <= -$signed(BW'(N));
`endif
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            dp_a     <= op_a;
            dp_b     <= op_b;
            ones     <= '0;
            state    <= LOAD;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            dp_load  <= 1'b1;
          end
        end
        LOAD, FILL, RUN: begin
          if (abort) begin
            state    <= IDLE;
            ones     <= '0;
            cyc      <= '0;
            op_ready <= 1'b1;
            busy     <= 1'b0;
            dp_load  <= 1'b0;
            dp_en    <= 1'b0;
          end else if (state == LOAD) begin
            dp_load <= 1'b0;
            dp_en   <= 1'b1;
            cyc     <= '0;
            state   <= (PIPE_LAT == 0) ? RUN : FILL;
          end else if (state == FILL) begin
            // FILL bits are pipeline warm-up and never reach the counter.
            if (cyc == CYC_W'(PIPE_LAT - 1)) begin
              cyc   <= '0;
              state <= RUN;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end else begin
            if (cyc == CYC_W'(N - 1)) begin
              res_count <= final_count;
`ifdef SC_BIPOLAR_OUT_EN
              res_bipolar <= $signed({final_count, 1'b0}) - $signed(BW'(N));
`endif
              cyc       <= '0;
              ones      <= '0;
              dp_en     <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              ones <= final_count;
              cyc  <= cyc + 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
          busy     <= 1'b0;
          dp_load  <= 1'b0;
          dp_en    <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_window_ctrl.sv
// Self-checking bench for sc_window_ctrl with a job-age reference model (SC_BIPOLAR_OUT_EN aware).
module tb_sc_window_ctrl;

  localparam int WL = 3;
  localparam int PL = 2;
  localparam int N  = 1 << WL;

  logic clk, rst_n;
  logic op_valid, op_ready, abort, dp_load, dp_en, sn_bit;
  logic res_valid, res_ready, busy;
  logic [3:0] op_a, op_b, dp_a, dp_b;
  logic [WL:0] res_count;
  logic [2:0] state_dbg;
`ifdef SC_BIPOLAR_OUT_EN
  logic signed [WL+1:0] res_bipolar;
`endif

  sc_window_ctrl #(.WIN_LOG2(WL), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .abort(abort),
    .dp_load(dp_load), .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b),
    .sn_bit(sn_bit), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count),
`ifdef SC_BIPOLAR_OUT_EN
    .res_bipolar(res_bipolar),
`endif
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a job is described only by its age in cycles since acceptance.
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  int         m_ones = 0;
  int         m_res  = 0;
  logic [3:0] m_a    = '0;
  logic [3:0] m_b    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_ones = 0; m_res = 0; m_a = '0; m_b = '0;
    end else if (!m_busy) begin
      if (op_valid) begin
        m_busy = 1'b1; m_age = 0; m_ones = 0; m_a = op_a; m_b = op_b;
      end
    end else if (m_age > PL + N) begin
      if (res_ready) m_busy = 1'b0;
    end else if (abort) begin
      m_busy = 1'b0; m_ones = 0;
    end else begin
      if (m_age >= PL + 1) m_ones += int'(sn_bit);
      m_age++;
      if (m_age == PL + N + 1) m_res = m_ones;
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_ready",  32'(op_ready),  32'(!m_busy));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("dp_load",   32'(dp_load),   32'(m_busy && m_age == 0));
      chk("dp_en",     32'(dp_en),     32'(m_busy && m_age >= 1 && m_age <= PL + N));
      chk("res_valid", 32'(res_valid), 32'(m_busy && m_age == PL + N + 1));
      chk("res_count", 32'(res_count), 32'(m_res));
      chk("dp_a",      32'(dp_a),      32'(m_a));
      chk("dp_b",      32'(dp_b),      32'(m_b));
`ifdef SC_BIPOLAR_OUT_EN
      chk("res_bipolar", 32'(res_bipolar), 32'(2 * m_res - N));
`endif
    end
  end

  // per-job monitor used by the literal checks
  int mon_load, mon_en, mon_rv_cyc, mon_rv_cnt, acc_cyc;
  bit mon_rv_seen, mon_rv_prev;
  always @(negedge clk) begin
    if (dp_load) mon_load++;
    if (dp_en) mon_en++;
    if (res_valid && !mon_rv_prev) begin
      mon_rv_seen = 1'b1; mon_rv_cyc = cyc; mon_rv_cnt = int'(res_count);
    end
    mon_rv_prev = res_valid;
  end

  function automatic logic pick(input int mode, input int j);
    case (mode)
      0: return 1'b1;
      1: return (j >= 1 && j <= PL);
      2: return (j >= PL + 1) && (((j - PL - 1) % 2) == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // driver: one job from accept to result handshake; called at posedge+1 with the DUT idle
  task automatic job(input logic [3:0] a, input logic [3:0] b, input int mode,
                     input int rdy_dly, input int abort_j, input bit abort_idle);
    mon_load = 0; mon_en = 0; mon_rv_seen = 1'b0;
    op_valid = 1'b1; op_a = a; op_b = b; abort = abort_idle;
    @(posedge clk); #1;
    acc_cyc = cyc;
    op_valid = 1'b0; op_a = 4'($urandom); op_b = 4'($urandom);
    for (int j = 0; j <= PL + N; j++) begin
      sn_bit = pick(mode, j);
      abort = (j == abort_j);
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    abort = 1'b0;
    for (int k = 0; k < rdy_dly; k++) begin
      res_ready = 1'b0;
      abort = 1'($urandom_range(0, 1));
      sn_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    abort = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic lit_full_job(input string tag, input int exp_cnt);
    chk({tag, "_latency"}, 32'(mon_rv_cyc - acc_cyc), 32'd11);
    chk({tag, "_load_cycles"}, 32'(mon_load), 32'd1);
    chk({tag, "_en_cycles"}, 32'(mon_en), 32'd10);
    chk({tag, "_count"}, 32'(mon_rv_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; abort = 1'b0;
    sn_bit = 1'b0; res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_op_ready", 32'(op_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_res_count", 32'(res_count), 32'd0);

    // all-ones window
    job(4'h8, 4'h8, 0, 0, -1, 1'b0);
    lit_full_job("ones", 8);
    // zeros in RUN, ones only during FILL
    job(4'h3, 4'hc, 1, 0, -1, 1'b0);
    lit_full_job("fill_ignored", 0);
    // alternating bits, slow consumer
    job(4'h5, 4'ha, 2, 5, -1, 1'b0);
    lit_full_job("alternate", 4);
    // abort on third RUN cycle, then a clean job
    job(4'h1, 4'h2, 0, 0, PL + 3, 1'b0);
    chk("abort_no_result", 32'(mon_rv_seen), 32'd0);
    job(4'h7, 4'h9, 0, 0, -1, 1'b1);
    lit_full_job("after_abort", 8);

    // reset pulled mid-FILL
    op_valid = 1'b1; op_a = 4'hf; op_b = 4'he; sn_bit = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_op_ready", 32'(op_ready), 32'd1);
    chk("async_dp_en", 32'(dp_en), 32'd0);
    chk("async_dp_a", 32'(dp_a), 32'd0);
    chk("async_res_count", 32'(res_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    job(4'h8, 4'h8, 0, 0, -1, 1'b0);
    lit_full_job("post_reset", 8);

    // randomized jobs
    for (int r = 0; r < 30; r++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        abort = 1'($urandom_range(0, 1)); sn_bit = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      abort = 1'b0;
      job(4'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PL + N)) : -1,
          1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
